// File: rtl/snake_pkg.sv
// snake_pkg: state, direction and status encodings shared by the snake engine
package snake_pkg;
  typedef enum logic [2:0] {S_INI, S_RUN, S_STEP, S_SCAN, S_COMMIT, S_LOSE, S_WIN} state_t;
  typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction
  function automatic logic [3:0] st_onehot(input state_t s);
    return s == S_INI ? 4'b0001 : s == S_LOSE ? 4'b0100 : s == S_WIN ? 4'b1000 : 4'b0010;
  endfunction
endpackage

// File: rtl/snake_lfsr16.sv
// snake_lfsr16: 16-bit Fibonacci LFSR, taps 16,14,13,11, used as the food position source
module snake_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] lfsr
);
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = en ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]} : lfsr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= SEED;
    else lfsr_q <= lfsr_d;
  assign lfsr = lfsr_q;
endmodule

// File: rtl/snake_core_param.sv
// snake_core_param: parametrised snake engine with a circular body buffer and a sequential self-collision scan
module snake_core_param
  import snake_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int MAX_LEN = 32,
  parameter int INIT_LEN = 3,
  parameter int TICK_DIV = 15000000,
  parameter int FOOD0_X = 10,
  parameter int FOOD0_Y = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int LW = $clog2(MAX_LEN + 1)
) (
  input  logic          ClkPort,
  input  logic          Reset_n,
  input  logic          BtnU_p,
  input  logic          BtnD_p,
  input  logic          BtnL_p,
  input  logic          BtnR_p,
  input  logic          Restart,
  output logic [3:0]    St,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [XW-1:0] food_x,
  output logic [YW-1:0] food_y,
  output logic [LW-1:0] length,
  output logic [15:0]   score,
  output logic          move_tick,
  input  logic [LW-1:0] q_idx,
  output logic [XW-1:0] q_x,
  output logic [YW-1:0] q_y,
  output logic          q_valid
);
  localparam int PW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TICK_DIV);
  state_t state_q, state_d;
  dir_t dir_q, dir_d, pend_q, pend_d, bdir;
  logic [TW-1:0] tick_q, tick_d;
  logic [PW-1:0] hp_q, hp_d, hp_c, scan_slot;
  logic [LW-1:0] len_q, len_d, scan_q, scan_d;
  logic [15:0] score_q, score_d, lfsr;
  logic [XW-1:0] fx_q, fx_d, nx_q, nx_d, qx_q, qx_d, hx, nx_c, fx_new;
  logic [YW-1:0] fy_q, fy_d, ny_q, ny_d, qy_q, qy_d, hy, ny_c, fy_new;
  logic [XW:0] rx;
  logic [YW:0] ry;
  logic [XW-1:0] bx_q [MAX_LEN];
  logic [XW-1:0] bx_d [MAX_LEN];
  logic [YW-1:0] by_q [MAX_LEN];
  logic [YW-1:0] by_d [MAX_LEN];
  logic grow_q, grow_d, mt_q, mt_d, qv_q, qv_d, oob, hit, last, btn, lfsr_unused;
  // logical body index i lives at slot (head pointer + i) mod MAX_LEN
  function automatic logic [PW-1:0] slot(input logic [PW-1:0] base, input logic [LW-1:0] i);
    return PW'((int'(base) + int'(i)) % MAX_LEN);
  endfunction
  snake_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (.clk(ClkPort), .rst_n(Reset_n), .en(1'b1), .lfsr(lfsr));
  assign lfsr_unused = ^lfsr;
  assign hx = bx_q[hp_q];
  assign hy = by_q[hp_q];
  assign nx_c = pend_q == DIR_L ? hx - 1'b1 : pend_q == DIR_R ? hx + 1'b1 : hx;
  assign ny_c = pend_q == DIR_U ? hy - 1'b1 : pend_q == DIR_D ? hy + 1'b1 : hy;
  assign oob = pend_q == DIR_L ? hx == '0 : pend_q == DIR_R ? hx == XW'(GRID_W - 1) :
               pend_q == DIR_U ? hy == '0 : hy == YW'(GRID_H - 1);
  assign scan_slot = slot(hp_q, scan_q);
  assign hit = bx_q[scan_slot] == nx_q && by_q[scan_slot] == ny_q;
  // the tail vacates its cell on a plain move, so it only counts when growing
  assign last = scan_q + 1'b1 == (grow_q ? len_q : len_q - 1'b1);
  assign hp_c = hp_q == '0 ? PW'(MAX_LEN - 1) : hp_q - 1'b1;
  assign btn = BtnU_p | BtnD_p | BtnL_p | BtnR_p;
  assign bdir = BtnU_p ? DIR_U : BtnD_p ? DIR_D : BtnL_p ? DIR_L : DIR_R;
  assign rx = {1'b0, lfsr[XW-1:0]};
  assign ry = {1'b0, lfsr[15 -: YW]};
  assign fx_new = XW'(rx >= (XW+1)'(GRID_W) ? rx - (XW+1)'(GRID_W) : rx);
  assign fy_new = YW'(ry >= (YW+1)'(GRID_H) ? ry - (YW+1)'(GRID_H) : ry);
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    pend_d = pend_q;
    tick_d = tick_q;
    hp_d = hp_q;
    len_d = len_q;
    score_d = score_q;
    fx_d = fx_q;
    fy_d = fy_q;
    nx_d = nx_q;
    ny_d = ny_q;
    grow_d = grow_q;
    scan_d = scan_q;
    bx_d = bx_q;
    by_d = by_q;
    mt_d = 1'b0;
    qx_d = bx_q[slot(hp_q, q_idx)];
    qy_d = by_q[slot(hp_q, q_idx)];
    qv_d = q_idx < len_q;
    case (state_q)
      S_INI: begin
        state_d = S_RUN;
        dir_d = DIR_R;
        pend_d = DIR_R;
        tick_d = '0;
        hp_d = '0;
        len_d = LW'(INIT_LEN);
        score_d = '0;
        fx_d = XW'(FOOD0_X);
        fy_d = YW'(FOOD0_Y);
        for (int i = 0; i < MAX_LEN; i++) begin
          bx_d[i] = XW'(GRID_W / 2 - i);
          by_d[i] = YW'(GRID_H / 2);
        end
      end
      S_RUN: begin
        tick_d = tick_q == TW'(TICK_DIV - 1) ? '0 : tick_q + 1'b1;
        state_d = tick_q == TW'(TICK_DIV - 1) ? S_STEP : S_RUN;
        pend_d = btn && bdir != opposite(dir_q) ? bdir : pend_q;
      end
      S_STEP: begin
        dir_d = pend_q;
        nx_d = nx_c;
        ny_d = ny_c;
        grow_d = nx_c == fx_q && ny_c == fy_q;
        scan_d = '0;
        state_d = oob ? S_LOSE : S_SCAN;
      end
      S_SCAN: begin
        scan_d = scan_q + 1'b1;
        state_d = hit ? S_LOSE : last ? S_COMMIT : S_SCAN;
      end
      S_COMMIT: begin
        hp_d = hp_c;
        bx_d[hp_c] = nx_q;
        by_d[hp_c] = ny_q;
        mt_d = 1'b1;
        len_d = grow_q ? len_q + 1'b1 : len_q;
        score_d = grow_q && !(&score_q) ? score_q + 1'b1 : score_q;
        fx_d = grow_q ? fx_new : fx_q;
        fy_d = grow_q ? fy_new : fy_q;
        state_d = grow_q && len_q + 1'b1 == LW'(MAX_LEN) ? S_WIN : S_RUN;
      end
      S_LOSE, S_WIN: state_d = Restart ? S_INI : state_q;
      default: state_d = S_INI;
    endcase
  end
  always_ff @(posedge ClkPort or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= S_INI;
      dir_q <= DIR_R;
      pend_q <= DIR_R;
      tick_q <= '0;
      hp_q <= '0;
      len_q <= LW'(INIT_LEN);
      score_q <= '0;
      fx_q <= XW'(FOOD0_X);
      fy_q <= YW'(FOOD0_Y);
      nx_q <= '0;
      ny_q <= '0;
      grow_q <= 1'b0;
      scan_q <= '0;
      mt_q <= 1'b0;
      qx_q <= '0;
      qy_q <= '0;
      qv_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        bx_q[i] <= XW'(GRID_W / 2 - i);
        by_q[i] <= YW'(GRID_H / 2);
      end
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      hp_q <= hp_d;
      len_q <= len_d;
      score_q <= score_d;
      fx_q <= fx_d;
      fy_q <= fy_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
      grow_q <= grow_d;
      scan_q <= scan_d;
      mt_q <= mt_d;
      qx_q <= qx_d;
      qy_q <= qy_d;
      qv_q <= qv_d;
      bx_q <= bx_d;
      by_q <= by_d;
    end
  assign St = st_onehot(state_q);
  assign head_x = hx;
  assign head_y = hy;
  assign food_x = fx_q;
  assign food_y = fy_q;
  assign length = len_q;
  assign score = score_q;
  assign move_tick = mt_q;
  assign q_x = qx_q;
  assign q_y = qy_q;
  assign q_valid = qv_q;
endmodule

// File: tb/tb_snake_core_param.sv
// tb_snake_core_param: three configurations run in turn; move_tick heads are checked against a scoreboard queue
module tb_snake_core_param;
  typedef struct {int id; int x; int y;} exp_t;
  logic clk = 1'b0;
  logic [2:0] rn = '0;
  logic bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0, rs = 1'b0;
  logic [3:0] qi = '0;
  logic [3:0] st [3];
  logic [3:0] hx [3];
  logic [3:0] hy [3];
  logic [3:0] fx [3];
  logic [3:0] fy [3];
  logic [3:0] ln [3];
  logic [3:0] qx [3];
  logic [3:0] qy [3];
  logic [15:0] sc [3];
  logic mt [3];
  logic qv [3];
  exp_t sb [$];
  int pass_cnt = 0, total_cnt = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    snake_core_param #(
      .GRID_W(16), .GRID_H(12), .MAX_LEN(8), .TICK_DIV(40),
      .INIT_LEN(g == 2 ? 5 : 3),
      .FOOD0_X(g == 0 ? 2 : g == 1 ? 10 : 0),
      .FOOD0_Y(g == 0 ? 2 : g == 1 ? 6 : 0),
      .LFSR_SEED(16'hACE1)
    ) u_dut (
      .ClkPort(clk), .Reset_n(rn[g]),
      .BtnU_p(bu), .BtnD_p(bd), .BtnL_p(bl), .BtnR_p(br), .Restart(rs),
      .St(st[g]), .head_x(hx[g]), .head_y(hy[g]), .food_x(fx[g]), .food_y(fy[g]),
      .length(ln[g]), .score(sc[g]), .move_tick(mt[g]),
      .q_idx(qi), .q_x(qx[g]), .q_y(qy[g]), .q_valid(qv[g])
    );
  end
  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic wait_tick(input int g, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mt[g] && n < 300);
    chk(name, int'(mt[g]), 1);
  endtask
  task automatic wait_st(input int g, input int val, input string name);
    int n = 0;
    while (int'(st[g]) != val && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(st[g]), val);
  endtask
  task automatic press(input int d);
    @(negedge clk);
    {bu, bd, bl, br} = 4'b1000 >> d;
    @(negedge clk);
    {bu, bd, bl, br} = 4'b0000;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++)
        if (mt[g]) begin
          if (sb.size() == 0) chk($sformatf("unexpected_move_tick_dut%0d", g), 1, 0);
          else begin
            e = sb.pop_front();
            chk("mt_dut_id", g, e.id);
            chk("mt_head_x", int'(hx[g]), e.x);
            chk("mt_head_y", int'(hy[g]), e.y);
          end
        end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_st", int'(st[0]), 1);
    chk("rst_head_x", int'(hx[0]), 8);
    chk("rst_head_y", int'(hy[0]), 6);
    chk("rst_len", int'(ln[0]), 3);
    chk("rst_score", int'(sc[0]), 0);
    chk("rst_food_x", int'(fx[0]), 2);
    chk("rst_qvalid", int'(qv[0]), 0);
    rn[0] = 1'b1;
    #1 chk("ini_st", int'(st[0]), 1);
    @(negedge clk);
    chk("run_st", int'(st[0]), 2);
    chk("run_head_x", int'(hx[0]), 8);
    sb.push_back('{0, 9, 6});
    press(2);
    wait_tick(0, "tick_a1");
    qi = 4'd2;
    @(negedge clk);
    chk("q2_x", int'(qx[0]), 7);
    chk("q2_y", int'(qy[0]), 6);
    chk("q2_valid", int'(qv[0]), 1);
    for (int x = 10; x <= 15; x++) begin
      sb.push_back('{0, x, 6});
      wait_tick(0, "tick_a_walk");
    end
    wait_st(0, 4, "lose_wall_st");
    chk("lose_head_x", int'(hx[0]), 15);
    chk("lose_head_y", int'(hy[0]), 6);
    chk("lose_len", int'(ln[0]), 3);
    press(0);
    repeat (5) @(negedge clk);
    chk("lose_hold_x", int'(hx[0]), 15);
    chk("lose_hold_st", int'(st[0]), 4);
    @(negedge clk);
    rs = 1'b1;
    @(negedge clk);
    rs = 1'b0;
    chk("restart_ini", int'(st[0]), 1);
    @(negedge clk);
    chk("restart_run", int'(st[0]), 2);
    chk("restart_head_x", int'(hx[0]), 8);
    chk("restart_len", int'(ln[0]), 3);
    sb.push_back('{0, 9, 6});
    wait_tick(0, "tick_a_restart");
    repeat (42) @(negedge clk);
    chk("prescan_head_x", int'(hx[0]), 9);
    rn[0] = 1'b0;
    #1 chk("midscan_rst_st", int'(st[0]), 1);
    chk("midscan_rst_len", int'(ln[0]), 3);
    chk("midscan_rst_head_x", int'(hx[0]), 8);
    repeat (60) @(negedge clk);
    rn[1] = 1'b1;
    sb.push_back('{1, 9, 6});
    sb.push_back('{1, 10, 6});
    wait_tick(1, "tick_b1");
    wait_tick(1, "tick_b2");
    chk("grow_len", int'(ln[1]), 4);
    chk("grow_score", int'(sc[1]), 1);
    chk("grow_food_moved", int'(fx[1] != 4'd10 || fy[1] != 4'd6), 1);
    chk("grow_food_y_in_grid", int'(fy[1] < 4'd12), 1);
    qi = 4'd3;
    @(negedge clk);
    chk("q3_x", int'(qx[1]), 7);
    chk("q3_y", int'(qy[1]), 6);
    chk("q3_valid", int'(qv[1]), 1);
    qi = 4'd4;
    @(negedge clk);
    chk("q4_valid", int'(qv[1]), 0);
    qi = 4'd0;
    @(negedge clk);
    chk("q0_x", int'(qx[1]), 10);
    rn[1] = 1'b0;
    rn[2] = 1'b1;
    repeat (2) @(negedge clk);
    press(0);
    sb.push_back('{2, 8, 5});
    wait_tick(2, "tick_c_up");
    press(2);
    sb.push_back('{2, 7, 5});
    wait_tick(2, "tick_c_left");
    press(1);
    wait_st(2, 4, "lose_self_st");
    chk("self_head_x", int'(hx[2]), 7);
    chk("self_head_y", int'(hy[2]), 5);
    chk("self_len", int'(ln[2]), 5);
    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
